// File: rtl/mac_rx.sv
// mac_rx: Ethernet MAC receive stage in the recovered RGMII receive clock domain.
// Strips preamble/SFD, filters on destination MAC (LOCAL_MAC or broadcast),
// captures source MAC and EtherType, forwards the payload with the FCS removed
// and keeps delivered/dropped frame counters.
// Build option: define MAC_RX_CRC_CHECK_EN to include the CRC-32 checker; without
// it the FCS is still stripped and o_crc_err only reports overlength frames.
// Output handshake: o_valid qualifies o_data for exactly one cycle, with no
// backpressure; o_last marks the final byte of a frame and o_crc_err is
// meaningful only while o_last is high.
module mac_rx #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
  parameter int          MAX_LEN   = 1522
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_end,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_crc_err,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_type,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_pre_cnt;
  logic [CW-1:0] r_byte_cnt;   // bytes after SFD consumed so far
  logic          r_uc_ok;      // destination still matches LOCAL_MAC
  logic          r_bc_ok;      // destination still matches broadcast
  logic [47:0]   r_src_sh;
  logic [7:0]    r_type_hi;
  logic [7:0]    r_dly [4];    // 4-byte delay line that hides the FCS
  logic [7:0]    r_p;          // pending byte, emitted once its successor is known
  logic [2:0]    r_pay_cnt;    // payload bytes seen, saturating at 5 (= P full)

  logic [7:0]    w_mac_byte;
  logic          w_uc_match;
  logic          w_bc_match;
  logic          w_p_full;
  logic          w_crc_bad;
  logic          w_unused;

  // i_rx_end duplicates ~i_rx_valid; frame boundaries come from i_rx_valid.
  assign w_unused = i_rx_end;

  // Select the LOCAL_MAC byte expected at the current destination byte index.
  always_comb begin
    w_mac_byte = LOCAL_MAC[7:0];
    case (r_byte_cnt[2:0])
      3'd0:    w_mac_byte = LOCAL_MAC[47:40];
      3'd1:    w_mac_byte = LOCAL_MAC[39:32];
      3'd2:    w_mac_byte = LOCAL_MAC[31:24];
      3'd3:    w_mac_byte = LOCAL_MAC[23:16];
      3'd4:    w_mac_byte = LOCAL_MAC[15:8];
      default: w_mac_byte = LOCAL_MAC[7:0];
    endcase
  end

  assign w_uc_match = r_uc_ok && (i_rx_data == w_mac_byte);
  assign w_bc_match = r_bc_ok && (i_rx_data == 8'hFF);
  assign w_p_full   = (r_pay_cnt == 3'd5);

`ifdef MAC_RX_CRC_CHECK_EN
  logic [31:0] r_crc;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  // CRC-32 over every byte after the SFD, FCS included; seeded on the SFD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (r_state == S_PRE && i_rx_valid && i_rx_data == 8'hD5) begin
      r_crc <= 32'hFFFF_FFFF;
    end else if (i_rx_valid && (r_state == S_HDR || r_state == S_DATA)) begin
      r_crc <= crc_byte(r_crc, i_rx_data);
    end
  end

  // Running over data plus FCS leaves the fixed CRC-32 residue when intact.
  assign w_crc_bad = (r_crc != 32'hDEBB_20E3);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Frame FSM, header capture, FCS-hiding pipeline, outputs and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pre_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_uc_ok     <= 1'b0;
      r_bc_ok     <= 1'b0;
      r_src_sh    <= '0;
      r_type_hi   <= '0;
      for (int i = 0; i < 4; i++) r_dly[i] <= '0;
      r_p         <= '0;
      r_pay_cnt   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_crc_err   <= 1'b0;
      o_src_mac   <= '0;
      o_type      <= '0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_crc_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid && i_rx_data == 8'h55) begin
            r_state   <= S_PRE;
            r_pre_cnt <= '0;
          end
        end
        S_PRE: begin
          if (!i_rx_valid) begin
            r_state <= S_IDLE;
          end else if (i_rx_data == 8'h55) begin
            // The IDLE byte was the first 0x55; a counter of 6 means 7 seen.
            if (r_pre_cnt == 3'd6) begin
              r_state    <= S_DROP;
              o_drop_cnt <= o_drop_cnt + 16'd1;
            end else begin
              r_pre_cnt <= r_pre_cnt + 3'd1;
            end
          end else if (i_rx_data == 8'hD5) begin
            r_state    <= S_HDR;
            r_byte_cnt <= '0;
            r_uc_ok    <= 1'b1;
            r_bc_ok    <= 1'b1;
          end else begin
            r_state    <= S_DROP;
            o_drop_cnt <= o_drop_cnt + 16'd1;
          end
        end
        S_HDR: begin
          if (!i_rx_valid) begin
            r_state    <= S_IDLE;
            o_drop_cnt <= o_drop_cnt + 16'd1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt < CW'(6)) begin
              r_uc_ok <= w_uc_match;
              r_bc_ok <= w_bc_match;
              if (r_byte_cnt == CW'(5) && !w_uc_match && !w_bc_match) begin
                r_state    <= S_DROP;
                o_drop_cnt <= o_drop_cnt + 16'd1;
              end
            end else if (r_byte_cnt < CW'(12)) begin
              r_src_sh <= {r_src_sh[39:0], i_rx_data};
            end else if (r_byte_cnt == CW'(12)) begin
              r_type_hi <= i_rx_data;
            end else begin
              o_src_mac <= r_src_sh;
              o_type    <= {r_type_hi, i_rx_data};
              r_pay_cnt <= '0;
              r_state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (!i_rx_valid) begin
            // The four bytes still in the delay line are the FCS.
            if (w_p_full) begin
              o_data      <= r_p;
              o_valid     <= 1'b1;
              o_last      <= 1'b1;
              o_crc_err   <= w_crc_bad;
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
              o_drop_cnt  <= o_drop_cnt + 16'd1;
            end
            r_pay_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (r_byte_cnt == CW'(MAX_LEN)) begin
            // One byte beyond MAX_LEN: close the frame as errored.
            if (w_p_full) begin
              o_data      <= r_p;
              o_valid     <= 1'b1;
              o_last      <= 1'b1;
              o_crc_err   <= 1'b1;
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
              o_drop_cnt  <= o_drop_cnt + 16'd1;
            end
            r_pay_cnt <= '0;
            r_state   <= S_DROP;
          end else begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_dly[0]   <= i_rx_data;
            r_dly[1]   <= r_dly[0];
            r_dly[2]   <= r_dly[1];
            r_dly[3]   <= r_dly[2];
            r_p        <= r_dly[3];
            if (w_p_full) begin
              o_data  <= r_p;
              o_valid <= 1'b1;
            end else begin
              r_pay_cnt <= r_pay_cnt + 3'd1;
            end
          end
        end
        S_DROP: begin
          if (!i_rx_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
